mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Synthesizable memory-side responder for the cache's memory request/response interface.
- Accepts single-beat 128-bit masked writes and 4-beat burst reads, then returns read data after a fixed programmable latency.
- Sits below the I/D caches as the main-memory model for simulation and the on-chip backing memory for ASIC test builds.

Parameters:
- ADDR_BITS, 28, width of mem_req_addr (128-bit beat address).
- DEPTH_BITS, 12, log2 of backing-store beats; address bits above this are ignored (aliasing).
- READ_LATENCY, 4, cycles from read-request fire to first mem_resp_valid; legal range 2..15.
- BURST_BEATS, 4, beats per read burst (fixed to 4; parameterised for checking only).

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- mem_req_valid  in  1  request address/command valid
- mem_req_ready  out  1  responder can accept a request
- mem_req_addr  in  ADDR_BITS  beat address
- mem_req_rw  in  1  1 = write, 0 = read
- mem_req_data_valid  in  1  write data beat valid
- mem_req_data_ready  out  1  responder can accept a write data beat
- mem_req_data_bits  in  128  write data
- mem_req_data_mask  in  16  byte enables; bit i enables bits [8i+7:8i]
- mem_resp_valid  out  1  read data beat valid, one cycle per beat
- mem_resp_data  out  128  read data beat

Behaviour:
- Reset (async assert, sync release): state = IDLE; mem_req_ready = 1, mem_req_data_ready = 1, mem_resp_valid = 0, mem_resp_data = 0, latency and beat counters = 0. Backing-store contents are not cleared.
- Reset mid-burst or mid-write: the operation is abandoned, mem_resp_valid drops in the same cycle, and no partial write is committed after reset asserts.
- All outputs are registered or decoded directly from state; no combinational path from inputs to outputs.
- States:
  - IDLE: mem_req_ready = 1, mem_req_data_ready = 1.
    - Request fire (valid & ready) with rw = 1, and data_valid in the same cycle: commit the write now and stay IDLE.
    - Request fire with rw = 1, no data_valid: latch the address and go to W_DATA.
    - Request fire with rw = 0: latch base = addr with the low 2 bits cleared, load the latency counter with READ_LATENCY-1, and go to R_WAIT.
    - data_valid without a write request: ignored, no store update.
  - W_DATA: mem_req_ready = 0, mem_req_data_ready = 1. On data_valid, write the latched address under the byte mask and go to IDLE. Otherwise wait indefinitely.
  - R_WAIT: both readies = 0. Decrement the counter. Issue the synchronous store read for beat 0 one cycle before the counter expires, so that beat 0 appears exactly READ_LATENCY cycles after the fire. At expiry go to R_BURST.
  - R_BURST: both readies = 0. mem_resp_valid = 1 for BURST_BEATS consecutive cycles, carrying beats base+0, +1, +2, +3 in order. The beat counter is 2 bits. After beat 3, go to IDLE: mem_resp_valid = 0 and mem_req_ready = 1 in the next cycle. The interface has no backpressure on responses.
- Write commit:
  - Store read-modify-write is per byte via the mask; a mask of 16'h0000 is a legal no-op.
  - A write followed immediately by a read of the same beat returns the new data (the write commits before the read is issued).
- Address handling:
  - Store index = addr[DEPTH_BITS-1:0].
  - Burst beat index = {base[DEPTH_BITS-1:2], beat}; wraps inside the 4-beat block, never crosses a block.
  - Addresses beyond the depth alias modulo 2^DEPTH_BITS.
- mem_resp_data holds the last beat after a burst; it is cleared only by reset.

Decomposition:
- Shared header MemResponderStates.vh, alongside const.vh: state encodings IDLE/W_DATA/R_WAIT/R_BURST and the BURST_BEATS constant.
- Widths come from the existing MEM_DATA_BITS in const.vh; mask width = MEM_DATA_BITS/8.
- One sub-module, mem_resp_store: 2^DEPTH_BITS x 128 single-port synchronous-read array with a 16-bit byte write mask, one access per cycle.
- The control FSM and counters stay in mem_responder.

Test Plan:
- Reset, then write addr 0x10, data 128'h0F..00 (byte i = i), mask FFFF, data in the same cycle; read addr 0x11 -> mem_resp_valid exactly 4 cycles after fire; beats 0x10..0x13 in order, beat 0 = 128'h0F..00; mem_req_ready returns 1 the cycle after beat 3.
- Write request at 0x20, data arriving 3 cycles later with mask 16'h000F, data 128'hFFFF..FF over a prior value of all zeros -> mem_req_ready = 0 while waiting; read-back of beat 0x20 = 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF.
- Cache-style dirty-line flush (4 request/data beat pairs, addresses 0x40..0x43) followed immediately by a read of 0x41 -> burst returns exactly the 4 flushed beats.
- data_valid with 128'hDEAD in IDLE and no request -> no store change (read-back unchanged).
- Assert reset during beat 1 of a burst -> mem_resp_valid = 0 in the same cycle; after release, state is IDLE, readies = 1, and the next read completes normally.
- READ_LATENCY = 2 and addr 0x1003 with DEPTH_BITS = 12 -> first beat 2 cycles after fire, data read from store index 0x000..0x003 (aliasing and block wrap).

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory-side responder.
package mem_responder_pkg;

  localparam int MEM_DATA_BITS = 128;
  localparam int MEM_MASK_BITS = MEM_DATA_BITS / 8;
  localparam int MEM_BURST_BEATS = 4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_W_DATA  = 2'd1,
    S_R_WAIT  = 2'd2,
    S_R_BURST = 2'd3
  } state_t;

  // Byte-granular merge of new data over an existing beat.
  function automatic logic [MEM_DATA_BITS-1:0] merge_bytes(
    input logic [MEM_DATA_BITS-1:0] old_beat,
    input logic [MEM_DATA_BITS-1:0] new_beat,
    input logic [MEM_MASK_BITS-1:0] mask
  );
    logic [MEM_DATA_BITS-1:0] res;
    res = old_beat;
    for (int i = 0; i < MEM_MASK_BITS; i++) begin
      if (mask[i]) begin
        res[8*i +: 8] = new_beat[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_resp_store.sv
// Single-port backing store: byte-masked writes, registered reads.
module mem_resp_store
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_BITS = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     we,
  input  logic [DEPTH_BITS-1:0]    index,
  input  logic [MEM_DATA_BITS-1:0] wdata,
  input  logic [MEM_MASK_BITS-1:0] mask,
  output logic [MEM_DATA_BITS-1:0] rdata
);

  logic [MEM_DATA_BITS-1:0] mem [2**DEPTH_BITS];

  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[index] <= merge_bytes(mem[index], wdata, mask);
    end
  end

  // Only the read register resets; array contents survive reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[index];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: masked single-beat writes, 4-beat burst reads
// returned after a fixed latency.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_BITS    = 28,
  parameter int DEPTH_BITS   = 12,
  parameter int READ_LATENCY = 4,
  parameter int BURST_BEATS  = MEM_BURST_BEATS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mem_req_valid,
  output logic                     mem_req_ready,
  input  logic [ADDR_BITS-1:0]     mem_req_addr,
  input  logic                     mem_req_rw,
  input  logic                     mem_req_data_valid,
  output logic                     mem_req_data_ready,
  input  logic [MEM_DATA_BITS-1:0] mem_req_data_bits,
  input  logic [MEM_MASK_BITS-1:0] mem_req_data_mask,
  output logic                     mem_resp_valid,
  output logic [MEM_DATA_BITS-1:0] mem_resp_data
);

  localparam logic [1:0] LAST_BEAT = 2'(BURST_BEATS - 1);
  localparam logic [3:0] LAT_LOAD  = 4'(READ_LATENCY - 1);
  localparam int         BLK_BITS  = DEPTH_BITS - 2;

  state_t state;
  state_t state_nx;

  logic [3:0]            lat_cnt;
  logic [1:0]            beat;
  logic [DEPTH_BITS-1:0] wr_addr;
  logic [BLK_BITS-1:0]   rd_blk;

  logic req_fire;
  logic wr_direct;
  logic wr_late;
  logic lat_last;
  logic burst_last;

  logic                  st_en;
  logic                  st_we;
  logic [DEPTH_BITS-1:0] st_idx;
  logic [1:0]            rd_beat;

  logic unused_addr;

  assign unused_addr = ^mem_req_addr[ADDR_BITS-1:DEPTH_BITS];

  assign req_fire   = mem_req_valid && (state == S_IDLE);
  assign wr_direct  = req_fire && mem_req_rw && mem_req_data_valid;
  assign wr_late    = (state == S_W_DATA) && mem_req_data_valid;
  assign lat_last   = (lat_cnt == 4'd1);
  assign burst_last = (beat == LAST_BEAT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (req_fire) begin
          if (!mem_req_rw) begin
            state_nx = S_R_WAIT;
          end else if (!mem_req_data_valid) begin
            state_nx = S_W_DATA;
          end
        end
      end
      S_W_DATA: begin
        if (mem_req_data_valid) begin
          state_nx = S_IDLE;
        end
      end
      S_R_WAIT: begin
        if (lat_last) begin
          state_nx = S_R_BURST;
        end
      end
      S_R_BURST: begin
        if (burst_last) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req_ready      = 1'b0;
    mem_req_data_ready = 1'b0;
    mem_resp_valid     = 1'b0;
    unique case (state)
      S_IDLE: begin
        mem_req_ready      = 1'b1;
        mem_req_data_ready = 1'b1;
      end
      S_W_DATA: begin
        mem_req_data_ready = 1'b1;
      end
      S_R_WAIT: begin
        mem_resp_valid = 1'b0;
      end
      S_R_BURST: begin
        mem_resp_valid = 1'b1;
      end
      default: begin
        mem_resp_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_cnt <= '0;
      beat    <= '0;
      wr_addr <= '0;
      rd_blk  <= '0;
    end else begin
      if (req_fire && !mem_req_rw) begin
        lat_cnt <= LAT_LOAD;
        beat    <= '0;
        rd_blk  <= mem_req_addr[DEPTH_BITS-1:2];
      end else if (state == S_R_WAIT) begin
        lat_cnt <= lat_cnt - 4'd1;
      end
      if (state == S_R_BURST) begin
        beat <= beat + 2'd1;
      end
      if (req_fire && mem_req_rw && !mem_req_data_valid) begin
        wr_addr <= mem_req_addr[DEPTH_BITS-1:0];
      end
    end
  end

  // Each store read is issued one cycle ahead of the beat it feeds.
  always_comb begin
    st_we   = 1'b0;
    st_en   = 1'b0;
    rd_beat = 2'd0;
    st_idx  = {rd_blk, rd_beat};
    if (!reset) begin
      st_we = wr_direct || wr_late;
      st_en = st_we
           || ((state == S_R_WAIT) && lat_last)
           || ((state == S_R_BURST) && !burst_last);
    end
    if (state == S_R_BURST) begin
      rd_beat = beat + 2'd1;
    end
    if (wr_direct) begin
      st_idx = mem_req_addr[DEPTH_BITS-1:0];
    end else if (wr_late) begin
      st_idx = wr_addr;
    end else begin
      st_idx = {rd_blk, rd_beat};
    end
  end

  mem_resp_store #(
    .DEPTH_BITS(DEPTH_BITS)
  ) u_store (
    .clk   (clk),
    .reset (reset),
    .en    (st_en),
    .we    (st_we),
    .index (st_idx),
    .wdata (mem_req_data_bits),
    .mask  (mem_req_data_mask),
    .rdata (mem_resp_data)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (latency 4 and 2) share
// one stimulus stream and are checked against an array model.
module tb_mem_responder;

  localparam int LAT_S = 4;
  localparam int LAT_F = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic [27:0]  req_addr;
  logic         req_rw;
  logic         data_valid;
  logic [127:0] data_bits;
  logic [15:0]  data_mask;

  logic         ready_s, dready_s, rvalid_s;
  logic [127:0] rdata_s;
  logic         ready_f, dready_f, rvalid_f;
  logic [127:0] rdata_f;

  int n_chk = 0;
  int n_fail = 0;

  logic [127:0] model [4096];

  always #5 clk = ~clk;

  mem_responder #(.READ_LATENCY(LAT_S)) u_slow (
    .clk(clk), .reset(reset),
    .mem_req_valid(req_valid), .mem_req_ready(ready_s),
    .mem_req_addr(req_addr), .mem_req_rw(req_rw),
    .mem_req_data_valid(data_valid), .mem_req_data_ready(dready_s),
    .mem_req_data_bits(data_bits), .mem_req_data_mask(data_mask),
    .mem_resp_valid(rvalid_s), .mem_resp_data(rdata_s)
  );

  mem_responder #(.READ_LATENCY(LAT_F)) u_fast (
    .clk(clk), .reset(reset),
    .mem_req_valid(req_valid), .mem_req_ready(ready_f),
    .mem_req_addr(req_addr), .mem_req_rw(req_rw),
    .mem_req_data_valid(data_valid), .mem_req_data_ready(dready_f),
    .mem_req_data_bits(data_bits), .mem_req_data_mask(data_mask),
    .mem_resp_valid(rvalid_f), .mem_resp_data(rdata_f)
  );

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int idx_of(input logic [27:0] a);
    return int'(a) % 4096;
  endfunction

  task automatic model_write(input logic [27:0] a, input logic [127:0] d,
                             input logic [15:0] m);
    int k;
    k = idx_of(a);
    for (int i = 0; i < 16; i++) begin
      if (m[i]) model[k][8*i +: 8] = d[8*i +: 8];
    end
  endtask

  task automatic idle_inputs();
    req_valid  = 1'b0;
    req_addr   = '0;
    req_rw     = 1'b0;
    data_valid = 1'b0;
    data_bits  = '0;
    data_mask  = '0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rdy_s"}, 128'(ready_s), 128'(1));
    chk({tag, "_drdy_s"}, 128'(dready_s), 128'(1));
    chk({tag, "_rdy_f"}, 128'(ready_f), 128'(1));
    chk({tag, "_drdy_f"}, 128'(dready_f), 128'(1));
  endtask

  task automatic wr_now(input logic [27:0] a, input logic [127:0] d,
                        input logic [15:0] m, input string tag);
    chk_idle(tag);
    req_valid  = 1'b1;
    req_rw     = 1'b1;
    req_addr   = a;
    data_valid = 1'b1;
    data_bits  = d;
    data_mask  = m;
    model_write(a, d, m);
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic wr_late(input logic [27:0] a, input logic [127:0] d,
                         input logic [15:0] m, input int gap,
                         input string tag);
    chk_idle(tag);
    req_valid = 1'b1;
    req_rw    = 1'b1;
    req_addr  = a;
    @(negedge clk);
    idle_inputs();
    for (int g = 0; g < gap; g++) begin
      chk({tag, "_wait_rdy"}, 128'(ready_s), 128'(0));
      chk({tag, "_wait_drdy"}, 128'(dready_s), 128'(1));
      chk({tag, "_wait_rdy_f"}, 128'(ready_f), 128'(0));
      @(negedge clk);
    end
    chk({tag, "_data_rdy"}, 128'(ready_s), 128'(0));
    chk({tag, "_data_drdy"}, 128'(dready_s), 128'(1));
    data_valid = 1'b1;
    data_bits  = d;
    data_mask  = m;
    model_write(a, d, m);
    @(negedge clk);
    idle_inputs();
    chk_idle({tag, "_done"});
  endtask

  task automatic stray(input logic [127:0] d, input string tag);
    chk_idle(tag);
    data_valid = 1'b1;
    data_bits  = d;
    data_mask  = 16'hFFFF;
    @(negedge clk);
    idle_inputs();
    chk_idle({tag, "_after"});
  endtask

  task automatic check_dut(input string tag, input int c, input int lat,
                           input int base, input logic rv,
                           input logic rdy, input logic [127:0] rd);
    logic ev;
    ev = (c >= lat) && (c < lat + 4);
    chk($sformatf("%s_c%0d_valid", tag, c), 128'(rv), 128'(ev));
    chk($sformatf("%s_c%0d_ready", tag, c), 128'(rdy),
        128'(c >= lat + 4));
    if (ev) begin
      chk($sformatf("%s_c%0d_beat", tag, c), rd, model[base + c - lat]);
    end else if (c >= lat + 4) begin
      chk($sformatf("%s_c%0d_hold", tag, c), rd, model[base + 3]);
    end
  endtask

  // rst_at > 0 asserts reset in that cycle after the regular checks.
  task automatic rd_burst(input logic [27:0] a, input string tag,
                          input int rst_at);
    int base;
    base = (idx_of(a) / 4) * 4;
    chk_idle(tag);
    req_valid = 1'b1;
    req_rw    = 1'b0;
    req_addr  = a;
    @(negedge clk);
    idle_inputs();
    for (int c = 1; c <= LAT_S + 4; c++) begin
      if (c > 1) @(negedge clk);
      check_dut({tag, "_s"}, c, LAT_S, base, rvalid_s, ready_s, rdata_s);
      check_dut({tag, "_f"}, c, LAT_F, base, rvalid_f, ready_f, rdata_f);
      if (c == rst_at) begin
        reset = 1'b1;
        #1;
        chk({tag, "_rst_valid_s"}, 128'(rvalid_s), 128'(0));
        chk({tag, "_rst_valid_f"}, 128'(rvalid_f), 128'(0));
        chk({tag, "_rst_rdy_s"}, 128'(ready_s), 128'(1));
        chk({tag, "_rst_drdy_s"}, 128'(dready_s), 128'(1));
        chk({tag, "_rst_data_s"}, rdata_s, 128'(0));
        @(negedge clk);
        reset = 1'b0;
        break;
      end
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    logic [27:0]  a;
    logic [127:0] d;
    logic [15:0]  m;
    int           op;

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_valid_s", 128'(rvalid_s), 128'(0));
    chk("reset_data_s", rdata_s, 128'(0));
    chk("reset_valid_f", 128'(rvalid_f), 128'(0));
    chk("reset_data_f", rdata_f, 128'(0));
    chk_idle("reset");
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 64; i++) begin
      wr_now(28'(i), rnd128(), 16'hFFFF, "prefill");
    end

    wr_now(28'h10, 128'h0F0E0D0C0B0A09080706050403020100,
           16'hFFFF, "t1_wr");
    rd_burst(28'h11, "t1_rd", 0);

    wr_now(28'h20, 128'h0, 16'hFFFF, "t2_zero");
    wr_late(28'h20, {128{1'b1}}, 16'h000F, 2, "t2_wr");
    rd_burst(28'h20, "t2_rd", 0);

    for (int i = 0; i < 4; i++) begin
      wr_now(28'h40 + 28'(i), rnd128(), 16'hFFFF, "t3_flush");
    end
    rd_burst(28'h41, "t3_rd", 0);

    wr_now(28'h10, rnd128(), 16'h0000, "t4_nomask");
    stray(128'hDEAD, "t4_stray");
    rd_burst(28'h10, "t4_rd", 0);

    rd_burst(28'h12, "t5_rst", LAT_S + 1);
    rd_burst(28'h12, "t5_after", 0);

    rd_burst(28'h1003, "t6_alias", 0);

    for (int n = 0; n < 40; n++) begin
      op = int'($urandom_range(0, 3));
      a  = (28'($urandom()) & 28'hFFFF000) | 28'($urandom_range(0, 63));
      d  = rnd128();
      m  = 16'($urandom());
      if ($urandom_range(0, 7) == 0) m = 16'h0000;
      case (op)
        0: wr_now(a, d, m, "rnd_wr");
        1: wr_late(a, d, m, int'($urandom_range(0, 3)), "rnd_wrl");
        2: stray(d, "rnd_stray");
        default: rd_burst(a, "rnd_rd", 0);
      endcase
    end
    rd_burst(28'h0, "final_rd", 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
